// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_pkg
// Description : Shared types and constants for the FIFO-drain UART
//               transmitter: FSM state encoding, bit-cycle counter width
//               helper and the nominal frame length.
// Macro       : FIFO_UART_TX_PARITY_EN - frame carries an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

  localparam int c_W_DEFAULT       = 4;
  localparam int c_CLK_DIV_DEFAULT = 16;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int c_PARITY_BITS = 1;
`else
  localparam int c_PARITY_BITS = 0;
`endif

  // All seven encodings are kept in every build so that state values stay
  // stable across configurations; without parity ST_PARITY is unreachable.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Width of a counter running 0..clk_div-1.
  function automatic int baud_cnt_width(input int clk_div);
    return (clk_div < 2) ? 1 : $clog2(clk_div);
  endfunction

  localparam int c_BAUD_CNT_W = baud_cnt_width(c_CLK_DIV_DEFAULT);

  // Serial frame length in clk cycles: start + data + parity + stop.
  function automatic int frame_len(input int w, input int clk_div);
    return (w + 2 + c_PARITY_BITS) * clk_div;
  endfunction

  localparam int c_FRAME_LEN = frame_len(c_W_DEFAULT, c_CLK_DIV_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_if
// Description : Bundle of the FIFO read port, enable and serial outputs of
//               the UART transmitter.
//   enable      - permits starting new frames
//   fifo_empty  - FIFO empty flag
//   fifo_data   - FIFO read data, valid the cycle after fifo_rd_n low
//   fifo_rd_n   - active-low FIFO read strobe
//   tx          - serial line, idles high
//   busy        - transmitter not idle
// Modports    : slave = transmitter, master = FIFO/controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if
  import fifo_uart_tx_pkg::*;
#(
  parameter int W = c_W_DEFAULT
);
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_rd_n;
  logic         tx;
  logic         busy;

  modport master (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd_n, tx, busy
  );

  modport slave (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd_n, tx, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_baud_tick
// Description : Bit-period counter. Counts 0..CLK_DIV-1 and wraps; tick is
//               high during the last cycle of each bit period. A synchronous
//               clear holds the count at zero.
//   clk     - clock
//   reset_n - asynchronous active-low reset
//   clr     - synchronous clear (count forced to 0 next cycle)
//   tick    - last cycle of the current bit period
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
  input  wire  clk,
  input  wire  reset_n,
  input  wire  clr,
  output logic tick
);

  localparam int                 c_CNT_W = baud_cnt_width(CLK_DIV);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : FIFO drain stage. Pops one word per frame through the FIFO's
//               active-low read strobe and shifts it out as an asynchronous
//               serial frame: start bit, W data bits LSB first, optional even
//               parity, one stop bit. Runs in the FIFO clock domain.
// Ports       : clk     - clock shared with the FIFO
//               reset_n - asynchronous active-low reset
//               bus     - fifo_uart_tx_if.slave (enable, fifo_empty,
//                         fifo_data in; fifo_rd_n, tx, busy out)
// Macro       : FIFO_UART_TX_PARITY_EN - adds the even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int W       = c_W_DEFAULT,
  parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
  input  wire            clk,
  input  wire            reset_n,
  fifo_uart_tx_if.slave  bus
);

  localparam int c_BIT_W = $clog2(W + 1);

  state_t             r_state;
  logic [W-1:0]       r_shift;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic               r_tx;
  logic               r_rd_n;
  logic               r_busy;
`ifdef FIFO_UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic         w_tick;
  logic         w_baud_clr;
  logic         w_start_ok;
  logic         w_last_bit;
  logic [W-1:0] w_shift_next;

  // The bit timer only runs while a bit is on the line, so every frame's
  // start bit begins from a zero count.
  assign w_baud_clr   = (r_state == ST_IDLE) || (r_state == ST_FETCH) ||
                        (r_state == ST_LATCH);
  assign w_start_ok   = bus.enable && !bus.fifo_empty;
  assign w_last_bit   = (r_bit_cnt == c_BIT_W'(W - 1));
  assign w_shift_next = r_shift >> 1;

  fifo_uart_tx_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_baud_clr),
    .tick    (w_tick)
  );

  // Outputs are registered: each transition loads the value the line must
  // carry in the destination state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_rd_n    <= 1'b1;
      r_busy    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state <= ST_FETCH;
            r_rd_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        ST_FETCH: begin
          r_state <= ST_LATCH;
          r_rd_n  <= 1'b1;
        end

        ST_LATCH: begin
          r_shift   <= bus.fifo_data;
          r_bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
          r_parity  <= 1'b0;
`endif
          r_state   <= ST_START;
          r_tx      <= 1'b0;
        end

        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= r_parity ^ r_shift[0];
`endif
            if (w_last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
              // Fold in the bit just sent to complete the even parity.
              r_state <= ST_PARITY;
              r_tx    <= r_parity ^ r_shift[0];
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_tx <= w_shift_next[0];
            end
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif

        ST_STOP: begin
          // enable and fifo_empty are only looked at here and in IDLE, so
          // changes during a frame never disturb it.
          if (w_tick) begin
            if (w_start_ok) begin
              r_state <= ST_FETCH;
              r_rd_n  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_rd_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx        = r_tx;
  assign bus.fifo_rd_n = r_rd_n;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire
